// File: rtl/add_pkg.sv
// Shared helpers for the adder/subtractor family.
// ovf_calc is the sign-based overflow test, kept here so ALU blocks can reuse it
// when they only have operand and result MSBs available.
package add_pkg;

   // Signed overflow: operands agree in sign but the result does not.
   function automatic logic ovf_calc(input logic msb_a, input logic msb_b, input logic msb_s);
      return (msb_a == msb_b) && (msb_s != msb_a);
   endfunction

endpackage

// File: rtl/add_chunk.sv
// CHUNK-bit combinational adder slice: sum, carry-out and the carry into its MSB.
// The carry into the MSB is recovered from the MSB sum bit, so the slice works for any CHUNK >= 1.
module add_chunk
   import add_pkg::*;
#(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             c_msb
);

   logic [CHUNK:0] total;

   // Widen by one bit so the carry-out falls out of the add directly.
   always_comb begin
      total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
      sum   = total[CHUNK-1:0];
      cout  = total[CHUNK];
      c_msb = total[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
   end

endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined WIDTH-bit adder/subtractor. Operands are split into STAGES chunks;
// stage k resolves chunk k using the carry registered by stage k-1, carrying
// skewed operand copies and already-resolved low sum chunks alongside.
// One global advance signal stalls the whole pipe when the consumer backs up.
module add_sub_pipe
   import add_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CHUNK = WIDTH / STAGES;

   if ((WIDTH % STAGES) != 0) begin : g_bad_split
      $error("add_sub_pipe: WIDTH must be a multiple of STAGES");
   end

   // Stage registers: index k holds what stage k produced.
   logic [STAGES-1:0]            valid_q, valid_d;
   logic [STAGES-1:0]            carry_q, carry_d;
   logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
   logic [STAGES-1:0][WIDTH-1:0] bb_q, bb_d;
   logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d;
   logic                         ovf_q, ovf_d;

   // What each stage sees on its input side this cycle.
   logic [STAGES-1:0]            valid_in;
   logic [STAGES-1:0]            carry_in;
   logic [STAGES-1:0][WIDTH-1:0] a_in;
   logic [STAGES-1:0][WIDTH-1:0] bb_in;
   logic [STAGES-1:0][WIDTH-1:0] sum_in;

   logic [STAGES-1:0][CHUNK-1:0] chunk_sum;
   logic [STAGES-1:0]            chunk_cout;
   logic [STAGES-1:0]            chunk_cmsb;

   logic adv;

   // The pipe moves whenever the output slot is empty or being drained.
   assign adv      = out_ready | ~valid_q[STAGES-1];
   assign in_ready = adv;

   // Stage 0 takes the (possibly inverted) operands; later stages take their predecessor.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      valid_in = '0;
      carry_in = '0;
      a_in     = '0;
      bb_in    = '0;
      sum_in   = '0;

      valid_in[0] = in_valid;
      carry_in[0] = sub ? ~cin : cin;
      a_in[0]     = a;
      bb_in[0]    = sub ? ~b : b;

      for (int k = 1; k < STAGES; k++) begin
         valid_in[k] = valid_q[k-1];
         carry_in[k] = carry_q[k-1];
         a_in[k]     = a_q[k-1];
         bb_in[k]    = bb_q[k-1];
         sum_in[k]   = sum_q[k-1];
      end
   end

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      add_chunk #(.CHUNK(CHUNK)) u_chunk (
         .a     (a_in[g][g*CHUNK +: CHUNK]),
         .b     (bb_in[g][g*CHUNK +: CHUNK]),
         .cin   (carry_in[g]),
         .sum   (chunk_sum[g]),
         .cout  (chunk_cout[g]),
         .c_msb (chunk_cmsb[g])
      );
   end

   // Next state: on advance every stage loads from its input side, otherwise all hold.
   always_comb begin
      valid_d = valid_q;
      carry_d = carry_q;
      a_d     = a_q;
      bb_d    = bb_q;
      sum_d   = sum_q;
      ovf_d   = ovf_q;
      if (adv) begin
         valid_d = valid_in;
         carry_d = chunk_cout;
         a_d     = a_in;
         bb_d    = bb_in;
         sum_d   = sum_in;
         for (int k = 0; k < STAGES; k++) begin
            sum_d[k][k*CHUNK +: CHUNK] = chunk_sum[k];
         end
         ovf_d = chunk_cmsb[STAGES-1] ^ chunk_cout[STAGES-1];
      end
   end

   // Control and result registers; reset clears every valid bit and the visible outputs.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so all stages shift from the same pre-edge values.
      if (rst) begin
         valid_q <= '0;
         carry_q <= '0;
         sum_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         ovf_q   <= ovf_d;
      end
   end

   // Skewed operand copies; their contents only matter behind a set valid bit.
   always_ff @(posedge clk) begin
      // NOTE: operand storage is deliberately left out of reset; the valid bits already qualify it.
      a_q  <= a_d;
      bb_q <= bb_d;
   end

   // The last stage's operand copy and the lower stages' MSB carries have no consumer.
   logic unused_bits;
   assign unused_bits = ^{a_q[STAGES-1], bb_q[STAGES-1], chunk_cmsb};

   assign out_valid = valid_q[STAGES-1];
   assign sum       = sum_q[STAGES-1];
   assign cout      = carry_q[STAGES-1];
   assign ovf       = ovf_q;

endmodule

// File: doc/add_sub_pipe.md
Name: add_sub_pipe

Overview:
- Parametrised, pipelined N-bit adder/subtractor; successor to the team's combinational 4-bit ripple adder.
- Splits the operands into STAGES equal chunks and resolves one chunk's carry per clock, so wide adds close timing.
- Adds a per-transaction add/sub mode, carry/borrow-in, signed overflow, and a valid/ready handshake on both sides.
- Sits between operand-producing logic and any consumer that can stall.

Parameters:
- WIDTH, 16, operand/result width in bits.
- STAGES, 4, pipeline depth and chunk count. WIDTH % STAGES == 0; CHUNK = WIDTH/STAGES. STAGES=1 gives a single registered adder.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts beat this cycle.
- a  in  WIDTH  operand A (unsigned or two's complement).
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0: a+b+cin; 1: a-b-cin.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result modulo 2^WIDTH.
- cout  out  1  add: carry-out; sub: 1 = no borrow (a >= b+cin unsigned).
- ovf  out  1  signed two's-complement overflow.

Behaviour:
- Reset: every stage valid bit cleared; out_valid=0; sum=0, cout=0, ovf=0. in_ready=1 in the first cycle after reset. rst overrides all other inputs; any in-flight beats are discarded.
- Effective operands: bb = sub ? ~b : b; c0 = sub ? ~cin : cin.
- Stage k (0..STAGES-1) adds chunk k of a and bb plus the carry registered by stage k-1 (stage 0 uses c0). It registers:
  - its CHUNK-bit partial sum;
  - its carry-out;
  - skewed copies of the remaining upper operand chunks;
  - the already-resolved lower sum chunks;
  - a valid bit.
- Global stall model: adv = out_ready | ~out_valid. in_ready = adv.
  - When adv=1, every stage register loads from its predecessor; stage 0 loads {in_valid, operands}.
  - When adv=0, all stages hold.
  - Bubbles are not collapsed.
- Latency: an accepted beat appears on out_valid exactly STAGES cycles after acceptance if adv stays 1. Throughput is one beat per cycle.
- Outputs are registered (final stage) and stay stable while out_valid=1 and out_ready=0.
- Valid-low stages may hold stale data; outputs are meaningful only when out_valid=1.
- cout = carry out of the top chunk (raw, not inverted, in sub mode).
- ovf = carry-into-MSB XOR carry-out-of-MSB; the final stage computes it internally.
- Boundaries:
  - Full wrap: all-ones + 1 → sum 0, cout 1.
  - Simultaneous in_valid and out_ready with a full pipe: accept and emit in the same cycle.
  - out_ready=1 with out_valid=0 is legal (no effect).
  - in_valid while in_ready=0: beat is not taken; the source must hold it.
  - rst asserted mid-stream clears all valid bits in one cycle.

Decomposition:
- No shared typedefs needed. A localparam CHUNK is derived in-module.
- Package add_pkg: function ovf_calc(msb_a, msb_b, msb_s) for reuse by the ALU team.
- One sub-module: add_chunk, a CHUNK-bit combinational adder with carry-in, carry-out, and carry-into-MSB output. It is instantiated STAGES times via generate.

Test Plan:
- WIDTH=4, STAGES=2, sub=0, cin=0; a=4'b1100, b=4'b1101 → after 2 cycles sum=4'b1001, cout=1, ovf=0.
- WIDTH=4, STAGES=2, sub=0, cin=0; a=4'b0100, b=4'b0101 → sum=4'b1001, cout=0, ovf=1 (4+5 overflows signed 4-bit).
- WIDTH=16, STAGES=4, sub=1, cin=0:
  - a=16'h0005, b=16'h0007 → sum=16'hFFFE, cout=0, ovf=0.
  - a=16'h8000, b=16'h0001 → sum=16'h7FFF, cout=1, ovf=1.
- Back-to-back stream of 8 beats with out_ready=1 → 8 results in order on consecutive cycles, first at cycle 4. Then hold out_ready=0 for 3 cycles mid-stream → in_ready=0, outputs frozen, no beat lost or duplicated.
- WIDTH=16: a=16'hFFFF, b=16'h0000, cin=1, sub=0 → sum=16'h0000, cout=1 (carry ripples across all chunks).
- Assert rst for one cycle with 3 beats in flight → out_valid=0 next cycle, sum=0. No stale beat emerges within the following STAGES cycles. The first beat after reset is accepted immediately.
